// File: rtl/rr_selector_pkg.sv
// ---------------------------------------------------------------------------
// rr_selector_pkg
//   Shared constants and helpers for the round-robin selector.
//   - HIGH/LOW      : request polarity values for the ACT parameter
//   - ENABLE/DISABLE: switch values for the MSB and RR parameters
//   - rotr()        : rotate the low n bits of a vector right by s (s < n)
//   - wrap_add()    : (a + b) mod n for a, b < n, without a divider
// ---------------------------------------------------------------------------
package rr_selector_pkg;

    localparam bit HIGH    = 1'b1;
    localparam bit LOW     = 1'b0;
    localparam bit ENABLE  = 1'b1;
    localparam bit DISABLE = 1'b0;

    // Widest lane count the rotate helper supports.
    localparam int MAX_IN = 64;

    // Bit i of the result is bit (i + s) mod n of v; bits >= n are zero.
    // Bits of v at or above n must already be zero.
    function automatic logic [MAX_IN-1:0] rotr(input logic [MAX_IN-1:0] v,
                                               input int unsigned       s,
                                               input int unsigned       n);
        logic [MAX_IN-1:0] mask;
        mask = (MAX_IN'(1) << n) - MAX_IN'(1);
        return ((v >> s) | (v << (n - s))) & mask;
    endfunction

    function automatic int unsigned wrap_add(input int unsigned a,
                                             input int unsigned b,
                                             input int unsigned n);
        int unsigned s;
        s = a + b;
        if (s >= n) s = s - n;
        return s;
    endfunction

endpackage

// File: rtl/rr_selector_pick.sv
// ---------------------------------------------------------------------------
// rr_selector_pick
//   Fixed-priority search over an N-bit request vector.
//   Ports:
//     i_vec : request bits, active-high
//     o_idx : index of the highest set bit (MSB=ENABLE) or the lowest
//             (MSB=DISABLE); zero when no bit is set
// ---------------------------------------------------------------------------
module rr_selector_pick
    import rr_selector_pkg::*;
#(
    parameter int N   = 4,
    parameter int IW  = 2,
    parameter bit MSB = ENABLE
) (
    input  logic [N-1:0]  i_vec,
    output logic [IW-1:0] o_idx
);

    // The last match in loop order wins, so the loop runs towards the
    // preferred end.
    always_comb begin
        o_idx = '0;
        if (MSB == ENABLE) begin
            for (int i = 0; i < N; i++)
                if (i_vec[i]) o_idx = IW'(i);
        end else begin
            for (int i = N - 1; i >= 0; i--)
                if (i_vec[i]) o_idx = IW'(i);
        end
    end

endmodule

// File: rtl/rr_selector.sv
// ---------------------------------------------------------------------------
// rr_selector
//   Picks one of IN request lanes per cycle (fixed or rotating priority)
//   and captures the winner's data word into a one-deep output register
//   with a valid/ready handshake.
//   Ports:
//     clk, reset : clock, synchronous active-high reset
//     req        : request bitmap, polarity set by ACT
//     in         : lane data, lane i is in[DATA*i +: DATA]
//     grant      : one-hot lane accepted this cycle (combinational)
//     out_valid  : output register holds a word
//     out_ready  : consumer takes the word this cycle
//     out        : captured data word
//     out_pos    : one-hot lane that produced out
//     out_cnt    : number of active requests at the capture cycle
// ---------------------------------------------------------------------------
module rr_selector
    import rr_selector_pkg::*;
#(
    parameter int DATA  = 32,
    parameter int IN    = 4,
    parameter bit ACT   = HIGH,
    parameter bit MSB   = ENABLE,
    parameter bit RR    = ENABLE,
    parameter int CNT_W = $clog2(IN + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [IN-1:0]      req,
    input  logic [DATA*IN-1:0] in,
    output logic [IN-1:0]      grant,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA-1:0]    out,
    output logic [IN-1:0]      out_pos,
    output logic [CNT_W-1:0]   out_cnt
);

    localparam int PTR_W = $clog2(IN);
    localparam logic [PTR_W-1:0] PTR_RST = (MSB == ENABLE) ? PTR_W'(IN - 1) : '0;

    logic [IN-1:0]    w_r;
    logic [IN-1:0]    w_rot;
    logic [IN-1:0]    w_win_oh;
    logic             w_any;
    logic             w_load;
    logic [PTR_W-1:0] w_k;
    logic [PTR_W-1:0] w_p;
    logic [PTR_W-1:0] w_ptr_nxt;
    int unsigned      w_shift;
    logic [DATA-1:0]  w_data;

    logic             r_valid;
    logic [DATA-1:0]  r_out;
    logic [IN-1:0]    r_pos;
    logic [CNT_W-1:0] r_cnt;
    logic [PTR_W-1:0] r_ptr;

    function automatic logic [CNT_W-1:0] popcount(input logic [IN-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < IN; i++)
            if (v[i]) c = c + CNT_W'(1);
        return c;
    endfunction

    assign w_r    = (ACT == HIGH) ? req : ~req;
    assign w_any  = |w_r;
    // Requests are ignored while reset is asserted.
    assign w_load = w_any & (~r_valid | out_ready) & ~reset;

    // Rotate r so the fixed-priority picker sees ptr as its first candidate:
    // ascending puts ptr at bit 0, descending puts ptr at bit IN-1.
    // In fixed mode ptr stays at its reset value, which makes the shift zero.
    always_comb begin
        w_shift = (MSB == ENABLE) ? wrap_add(32'(r_ptr), 1, 32'(IN)) : 32'(r_ptr);
        w_rot   = IN'(rotr(MAX_IN'(w_r), w_shift, 32'(IN)));
    end

    rr_selector_pick #(
        .N   (IN),
        .IW  (PTR_W),
        .MSB (MSB)
    ) u_pick (
        .i_vec (w_rot),
        .o_idx (w_k)
    );

    // Undo the rotation to get the real lane, then derive the next pointer
    // one step past the winner in the search direction.
    always_comb begin
        w_p       = PTR_W'(wrap_add(32'(w_k), w_shift, 32'(IN)));
        w_win_oh  = IN'(1) << w_p;
        w_ptr_nxt = (MSB == ENABLE) ? PTR_W'(wrap_add(32'(w_p), 32'(IN - 1), 32'(IN)))
                                    : PTR_W'(wrap_add(32'(w_p), 1, 32'(IN)));
        w_data    = '0;
        for (int i = 0; i < IN; i++)
            if (w_win_oh[i]) w_data = in[DATA*i +: DATA];
    end

    assign grant = w_load ? w_win_oh : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_out   <= '0;
            r_pos   <= '0;
            r_cnt   <= '0;
            r_ptr   <= PTR_RST;
        end else if (w_load) begin
            r_valid <= 1'b1;
            r_out   <= w_data;
            r_pos   <= w_win_oh;
            r_cnt   <= popcount(w_r);
            if (RR == ENABLE) r_ptr <= w_ptr_nxt;
        end else if (r_valid && out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign out_valid = r_valid;
    assign out       = r_out;
    assign out_pos   = r_pos;
    assign out_cnt   = r_cnt;

endmodule

// File: tb/tb_rr_selector.sv
// ---------------------------------------------------------------------------
// tb_rr_selector
//   Four instances: u0 ascending round-robin (main), u1 active-low requests,
//   u2 fixed priority high-first, u3 three lanes descending round-robin.
// ---------------------------------------------------------------------------
module tb_rr_selector;
    import rr_selector_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic [3:0]   req [4];
    logic         rdy [4];
    logic [127:0] din;

    logic [3:0]  g0, g1, g2;
    logic [2:0]  g3;
    logic        v0, v1, v2, v3;
    logic [31:0] o0, o1, o2, o3;
    logic [3:0]  p0, p1, p2;
    logic [2:0]  p3;
    logic [2:0]  c0, c1, c2;
    logic [1:0]  c3;

    logic [3:0]  gnt  [4];
    logic        vld  [4];
    logic [31:0] dout [4];
    logic [3:0]  pos  [4];
    logic [2:0]  cnt  [4];

    always_comb begin
        gnt[0] = g0; gnt[1] = g1; gnt[2] = g2; gnt[3] = {1'b0, g3};
        vld[0] = v0; vld[1] = v1; vld[2] = v2; vld[3] = v3;
        dout[0] = o0; dout[1] = o1; dout[2] = o2; dout[3] = o3;
        pos[0] = p0; pos[1] = p1; pos[2] = p2; pos[3] = {1'b0, p3};
        cnt[0] = c0; cnt[1] = c1; cnt[2] = c2; cnt[3] = {1'b0, c3};
    end

    rr_selector #(.DATA(32), .IN(4), .ACT(HIGH), .MSB(DISABLE), .RR(ENABLE)) u0 (
        .clk(clk), .reset(rst), .req(req[0]), .in(din), .grant(g0), .out_valid(v0),
        .out_ready(rdy[0]), .out(o0), .out_pos(p0), .out_cnt(c0));
    rr_selector #(.DATA(32), .IN(4), .ACT(LOW), .MSB(DISABLE), .RR(ENABLE)) u1 (
        .clk(clk), .reset(rst), .req(req[1]), .in(din), .grant(g1), .out_valid(v1),
        .out_ready(rdy[1]), .out(o1), .out_pos(p1), .out_cnt(c1));
    rr_selector #(.DATA(32), .IN(4), .ACT(HIGH), .MSB(ENABLE), .RR(DISABLE)) u2 (
        .clk(clk), .reset(rst), .req(req[2]), .in(din), .grant(g2), .out_valid(v2),
        .out_ready(rdy[2]), .out(o2), .out_pos(p2), .out_cnt(c2));
    rr_selector #(.DATA(32), .IN(3), .ACT(HIGH), .MSB(ENABLE), .RR(ENABLE)) u3 (
        .clk(clk), .reset(rst), .req(req[3][2:0]), .in(din[95:0]), .grant(g3), .out_valid(v3),
        .out_ready(rdy[3]), .out(o3), .out_pos(p3), .out_cnt(c3));

    localparam int NN   [4] = '{4, 4, 4, 3};
    localparam bit ACTH [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    localparam bit MSBV [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    localparam bit RRV  [4] = '{1'b1, 1'b1, 1'b0, 1'b1};

    int total = 0;
    int bad   = 0;

    // Reference model state per instance.
    bit          m_valid [4];
    logic [31:0] m_out   [4];
    logic [3:0]  m_pos   [4];
    int          m_cnt   [4];
    int          m_ptr   [4];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset;
        for (int k = 0; k < 4; k++) begin
            m_valid[k] = 1'b0;
            m_out[k]   = '0;
            m_pos[k]   = '0;
            m_cnt[k]   = 0;
            m_ptr[k]   = MSBV[k] ? NN[k] - 1 : 0;
        end
    endtask

    task automatic do_reset;
        rst = 1'b1;
        for (int k = 0; k < 4; k++) rdy[k] = 1'b1;
        tick;
        tick;
        rst = 1'b0;
        model_reset;
    endtask

    // Walk the lanes in priority order from the spec's rules; -1 = no load.
    function automatic int pick(int k);
        logic [3:0] r;
        int n;
        int lane;
        n = NN[k];
        r = ACTH[k] ? req[k] : ~req[k];
        if (rst) return -1;
        if (m_valid[k] && !rdy[k]) return -1;
        for (int d = 0; d < n; d++) begin
            if (RRV[k]) lane = MSBV[k] ? (m_ptr[k] - d + n) % n : (m_ptr[k] + d) % n;
            else        lane = MSBV[k] ? n - 1 - d : d;
            if (r[lane]) return lane;
        end
        return -1;
    endfunction

    task automatic model_step(int k, int w);
        logic [3:0] r;
        int c;
        r = ACTH[k] ? req[k] : ~req[k];
        if (rst) begin
            m_valid[k] = 1'b0; m_out[k] = '0; m_pos[k] = '0; m_cnt[k] = 0;
            m_ptr[k] = MSBV[k] ? NN[k] - 1 : 0;
        end else if (w >= 0) begin
            c = 0;
            for (int i = 0; i < NN[k]; i++) if (r[i]) c++;
            m_valid[k] = 1'b1;
            m_out[k]   = din[32*w +: 32];
            m_pos[k]   = 4'(1 << w);
            m_cnt[k]   = c;
            if (RRV[k]) m_ptr[k] = MSBV[k] ? (w - 1 + NN[k]) % NN[k] : (w + 1) % NN[k];
        end else if (m_valid[k] && rdy[k]) begin
            m_valid[k] = 1'b0;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin req[k] = 4'b1111; rdy[k] = 1'b1; end
        tick;
        tick;
        #1;
        total++; if (g0 !== 4'b0000) begin bad++; $display("FAIL reset_grant got=%b want=0000", g0); end
        total++; if (v0 !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", v0); end
        total++; if (o0 !== 32'd0) begin bad++; $display("FAIL reset_out got=%0h want=0", o0); end
        total++; if (c0 !== 3'd0) begin bad++; $display("FAIL reset_cnt got=%0d want=0", c0); end
        total++; if (p0 !== 4'b0000) begin bad++; $display("FAIL reset_pos got=%b want=0000", p0); end
        rst = 1'b0;
        #1;
        total++; if (g0 !== 4'b0001) begin bad++; $display("FAIL reset_first_grant got=%b want=0001", g0); end
        tick;
        #1;
        total++; if (v0 !== 1'b1) begin bad++; $display("FAIL reset_first_valid got=%b want=1", v0); end
        total++; if (o0 !== 32'd1) begin bad++; $display("FAIL reset_first_out got=%0h want=1", o0); end
        total++; if (p0 !== 4'b0001) begin bad++; $display("FAIL reset_first_pos got=%b want=0001", p0); end
        total++; if (c0 !== 3'd4) begin bad++; $display("FAIL reset_first_cnt got=%0d want=4", c0); end
    endtask

    task automatic test_rotate;
        logic [3:0] eg [5];
        int         eo [5];
        eg = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        eo = '{1, 2, 3, 4, 1};
        do_reset;
        req[0] = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            #1;
            total++; if (g0 !== eg[i]) begin bad++; $display("FAIL rotate_grant[%0d] got=%b want=%b", i, g0, eg[i]); end
            if (i > 0) begin
                total++; if (o0 !== 32'(eo[i-1])) begin bad++; $display("FAIL rotate_out[%0d] got=%0h want=%0h", i, o0, eo[i-1]); end
            end
            tick;
        end
        #1;
        total++; if (o0 !== 32'(eo[4])) begin bad++; $display("FAIL rotate_out_last got=%0h want=%0h", o0, eo[4]); end
    endtask

    task automatic test_sparse;
        logic [3:0] eg [3];
        int         eo [3];
        eg = '{4'b0010, 4'b1000, 4'b0010};
        eo = '{2, 4, 2};
        do_reset;
        req[0] = 4'b1010;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (g0 !== eg[i]) begin bad++; $display("FAIL sparse_grant[%0d] got=%b want=%b", i, g0, eg[i]); end
            if (i > 0) begin
                total++; if (o0 !== 32'(eo[i-1])) begin bad++; $display("FAIL sparse_out[%0d] got=%0h want=%0h", i, o0, eo[i-1]); end
            end
            tick;
        end
        #1;
        total++; if (o0 !== 32'(eo[2])) begin bad++; $display("FAIL sparse_out_last got=%0h want=%0h", o0, eo[2]); end
    endtask

    task automatic test_backpressure;
        do_reset;
        req[0] = 4'b0010;
        #1;
        total++; if (g0 !== 4'b0010) begin bad++; $display("FAIL bp_first_grant got=%b want=0010", g0); end
        tick;
        req[0] = 4'b0100;
        rdy[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (g0 !== 4'b0000) begin bad++; $display("FAIL bp_grant[%0d] got=%b want=0000", i, g0); end
            total++; if (v0 !== 1'b1) begin bad++; $display("FAIL bp_valid[%0d] got=%b want=1", i, v0); end
            total++; if (o0 !== 32'd2) begin bad++; $display("FAIL bp_out[%0d] got=%0h want=2", i, o0); end
            total++; if (p0 !== 4'b0010) begin bad++; $display("FAIL bp_pos[%0d] got=%b want=0010", i, p0); end
            total++; if (c0 !== 3'd1) begin bad++; $display("FAIL bp_cnt[%0d] got=%0d want=1", i, c0); end
            tick;
        end
        rdy[0] = 1'b1;
        #1;
        total++; if (g0 !== 4'b0100) begin bad++; $display("FAIL bp_release_grant got=%b want=0100", g0); end
        tick;
        #1;
        total++; if (o0 !== 32'd3) begin bad++; $display("FAIL bp_release_out got=%0h want=3", o0); end
        total++; if (v0 !== 1'b1) begin bad++; $display("FAIL bp_release_valid got=%b want=1", v0); end
        total++; if (p0 !== 4'b0100) begin bad++; $display("FAIL bp_release_pos got=%b want=0100", p0); end
    endtask

    task automatic test_drain;
        req[0] = 4'b0000;
        #1;
        total++; if (g0 !== 4'b0000) begin bad++; $display("FAIL drain_grant got=%b want=0000", g0); end
        tick;
        #1;
        total++; if (v0 !== 1'b0) begin bad++; $display("FAIL drain_valid got=%b want=0", v0); end
        total++; if (o0 !== 32'd3) begin bad++; $display("FAIL drain_out_hold got=%0h want=3", o0); end
        total++; if (p0 !== 4'b0100) begin bad++; $display("FAIL drain_pos_hold got=%b want=0100", p0); end
        req[0] = 4'b1000;
        #1;
        total++; if (g0 !== 4'b1000) begin bad++; $display("FAIL drain_new_grant got=%b want=1000", g0); end
        tick;
        #1;
        total++; if (o0 !== 32'd4) begin bad++; $display("FAIL drain_new_out got=%0h want=4", o0); end
        total++; if (v0 !== 1'b1) begin bad++; $display("FAIL drain_new_valid got=%b want=1", v0); end
        total++; if (c0 !== 3'd1) begin bad++; $display("FAIL drain_new_cnt got=%0d want=1", c0); end
    endtask

    task automatic test_variants;
        logic [2:0] eg3 [4];
        int         eo3 [4];
        eg3 = '{3'b100, 3'b010, 3'b001, 3'b100};
        eo3 = '{3, 2, 1, 3};
        req[1] = 4'b1110;
        req[2] = 4'b1111;
        req[3] = 4'b0111;
        do_reset;
        for (int i = 0; i < 4; i++) begin
            #1;
            total++; if (g1 !== 4'b0001) begin bad++; $display("FAIL actlow_grant[%0d] got=%b want=0001", i, g1); end
            total++; if (g2 !== 4'b1000) begin bad++; $display("FAIL fixed_grant[%0d] got=%b want=1000", i, g2); end
            total++; if (g3 !== eg3[i]) begin bad++; $display("FAIL in3_grant[%0d] got=%b want=%b", i, g3, eg3[i]); end
            if (i > 0) begin
                total++; if (o1 !== 32'd1) begin bad++; $display("FAIL actlow_out[%0d] got=%0h want=1", i, o1); end
                total++; if (o2 !== 32'd4) begin bad++; $display("FAIL fixed_out[%0d] got=%0h want=4", i, o2); end
                total++; if (c2 !== 3'd4) begin bad++; $display("FAIL fixed_cnt[%0d] got=%0d want=4", i, c2); end
                total++; if (o3 !== 32'(eo3[i-1])) begin bad++; $display("FAIL in3_out[%0d] got=%0h want=%0h", i, o3, eo3[i-1]); end
                total++; if (c3 !== 2'd3) begin bad++; $display("FAIL in3_cnt[%0d] got=%0d want=3", i, c3); end
            end
            tick;
        end
    endtask

    task automatic test_random;
        int w [4];
        for (int k = 0; k < 4; k++) req[k] = 4'b0000;
        do_reset;
        for (int cyc = 0; cyc < 600; cyc++) begin
            rst = ($urandom_range(0, 59) == 0);
            din = {$urandom, $urandom, $urandom, $urandom};
            for (int k = 0; k < 4; k++) begin
                req[k] = ($urandom_range(0, 3) == 0) ? (ACTH[k] ? 4'b0000 : 4'b1111) : 4'($urandom);
                rdy[k] = ($urandom_range(0, 3) != 0);
            end
            #1;
            for (int k = 0; k < 4; k++) begin
                w[k] = pick(k);
                total++; if (gnt[k] !== ((w[k] < 0) ? 4'b0000 : 4'(1 << w[k])))
                    begin bad++; $display("FAIL rand_grant u%0d cyc%0d got=%b want_lane=%0d", k, cyc, gnt[k], w[k]); end
                total++; if (vld[k] !== m_valid[k])
                    begin bad++; $display("FAIL rand_valid u%0d cyc%0d got=%b want=%b", k, cyc, vld[k], m_valid[k]); end
                total++; if (dout[k] !== m_out[k])
                    begin bad++; $display("FAIL rand_out u%0d cyc%0d got=%0h want=%0h", k, cyc, dout[k], m_out[k]); end
                total++; if (pos[k] !== m_pos[k])
                    begin bad++; $display("FAIL rand_pos u%0d cyc%0d got=%b want=%b", k, cyc, pos[k], m_pos[k]); end
                total++; if (cnt[k] !== 3'(m_cnt[k]))
                    begin bad++; $display("FAIL rand_cnt u%0d cyc%0d got=%0d want=%0d", k, cyc, cnt[k], m_cnt[k]); end
                total++; if (!$onehot0(gnt[k]))
                    begin bad++; $display("FAIL rand_grant_onehot u%0d cyc%0d got=%b want=onehot0", k, cyc, gnt[k]); end
                if (vld[k]) begin
                    total++; if (!$onehot(pos[k]))
                        begin bad++; $display("FAIL rand_pos_onehot u%0d cyc%0d got=%b want=onehot", k, cyc, pos[k]); end
                end
                if (vld[k] && !rdy[k]) begin
                    total++; if (gnt[k] !== 4'b0000)
                        begin bad++; $display("FAIL rand_bp_grant u%0d cyc%0d got=%b want=0000", k, cyc, gnt[k]); end
                end
            end
            for (int k = 0; k < 4; k++) model_step(k, w[k]);
            tick;
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        din = {32'd4, 32'd3, 32'd2, 32'd1};
        for (int k = 0; k < 4; k++) begin req[k] = 4'b0000; rdy[k] = 1'b1; end
        model_reset;
        test_reset;
        test_rotate;
        test_sparse;
        test_backpressure;
        test_drain;
        test_variants;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
